// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide unit.
package div_pkg;

  localparam int unsigned XLEN = 32;

  // Low two bits of the RV32M funct3 for the divide group.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } func3_code_e;

  // Wrapper control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/divu_core.sv
// Unsigned restoring divider: one quotient bit per clock, W iterations.
module divu_core
  import div_pkg::*;
#(
  parameter int unsigned W = XLEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done_c,
  output logic [W-1:0] o_quotient,
  output logic [W-1:0] o_remainder
);

  localparam int unsigned CNT_W = $clog2(W + 1);

  logic [W-1:0]     r_quo;
  logic [W-1:0]     r_rem;
  logic [W-1:0]     r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [W:0]       w_rem_sh;
  logic             w_ge;
  logic [W-1:0]     w_sub;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The shifted remainder is W+1 bits wide; after a successful subtract the
  // result is below the divisor, so the low W bits of the difference suffice.
  always_comb begin
    w_rem_sh = {r_rem, r_quo[W-1]};
    w_ge     = (w_rem_sh >= {1'b0, r_div});
    w_sub    = w_rem_sh[W-1:0] - r_div;
  end

  // Operand load on start, then W iterations while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_quo  <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
      r_cnt  <= CNT_W'(W);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_quo <= {r_quo[W-2:0], w_ge};
      r_rem <= w_ge ? w_sub : w_rem_sh[W-1:0];
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done_c    = r_busy && (r_cnt == CNT_W'(1));
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/divider_wrapper.sv
// RV32M DIV/DIVU/REM/REMU unit: sign handling around an unsigned iterative core.
module divider_wrapper
  import div_pkg::*;
#(
  parameter int unsigned XLEN = div_pkg::XLEN
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            go,
  input  logic [1:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            done,
  output logic [XLEN-1:0] rd
);

  state_e          r_state;
  state_e          w_next;

  func3_code_e     w_op;
  logic            w_signed;
  logic            w_is_rem;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;

  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_done;
  logic [XLEN-1:0] r_rd;

  logic            w_start;
  logic            w_rd_we;
  logic            w_done_next;
  logic [XLEN-1:0] w_result;

  logic            w_core_busy;
  logic            w_core_done_c;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;

  // Operand decode: signed ops divide absolute values, unsigned ops raw values.
  always_comb begin
    w_op     = func3_code_e'(func3);
    w_signed = (w_op == DIV) || (w_op == REM);
    w_is_rem = (w_op == REM) || (w_op == REMU);
    w_neg_a  = w_signed & rs1[XLEN-1];
    w_neg_b  = w_signed & rs2[XLEN-1];
    w_mag_a  = w_neg_a ? (~rs1 + XLEN'(1)) : rs1;
    w_mag_b  = w_neg_b ? (~rs2 + XLEN'(1)) : rs2;
  end

  divu_core #(
    .W (XLEN)
  ) u_core (
    .clk         (clk),
    .rst         (clr),
    .i_start     (w_start),
    .i_dividend  (w_mag_a),
    .i_divisor   (w_mag_b),
    .o_busy      (w_core_busy),
    .o_done_c    (w_core_done_c),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, core start and final sign correction.
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_rd_we     = 1'b0;
    w_done_next = 1'b0;
    w_result    = '0;
    case (r_state)
      ST_IDLE: begin
        if (go) begin
          w_start = 1'b1;
          w_next  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_core_done_c) begin
          w_next = ST_FIX;
        end else if (!w_core_busy) begin
          w_next = ST_IDLE;
        end
      end
      ST_FIX: begin
        w_rd_we     = 1'b1;
        w_done_next = 1'b1;
        if (r_is_rem) begin
          w_result = r_neg_r ? (~w_rem + XLEN'(1)) : w_rem;
        end else begin
          w_result = r_neg_q ? (~w_quo + XLEN'(1)) : w_quo;
        end
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Capture operation kind and sign fixes at start. A zero divisor never
  // negates the quotient, so DIV by zero stays all-ones like DIVU.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_start) begin
      r_is_rem <= w_is_rem;
      r_neg_q  <= w_signed & (w_neg_a ^ w_neg_b) & (rs2 != '0);
      r_neg_r  <= w_neg_a;
    end
  end

  // Result and one-cycle done pulse.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_done <= 1'b0;
      r_rd   <= '0;
    end else begin
      r_done <= w_done_next;
      if (w_rd_we) begin
        r_rd <= w_result;
      end
    end
  end

  assign done = r_done;
  assign rd   = r_rd;

endmodule

// File: tb/tb_divider_wrapper.sv
// Scoreboard bench for divider_wrapper: directed vectors, latency and done-pulse checks.
module tb_divider_wrapper;

  logic        clk = 1'b0;
  logic        clr;
  logic        go;
  logic [1:0]  func3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        done;
  logic [31:0] rd;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rises = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  divider_wrapper dut (
    .clk   (clk),
    .clr   (clr),
    .go    (go),
    .func3 (func3),
    .rs1   (rs1),
    .rs2   (rs2),
    .done  (done),
    .rd    (rd)
  );

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every done; flag missing, late or doubled pulses.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      chk("done_single_cycle", {31'b0, prev_done}, 32'd0);
      if (prev_done !== 1'b1) rises = rises + 1;
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        chk("result", rd, sb[0].val);
        chk("latency", 32'(cyc), 32'(sb[0].cyc));
        void'(sb.pop_front());
      end
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      chk("done_timeout", {31'b0, done}, 32'd1);
      void'(sb.pop_front());
    end
    prev_done = done;
  end

  // Issue one op at a negedge, scramble inputs after go, wait for its done.
  task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit poke_go, input bit hold_chk);
    int n;
    exp_t e;
    e.val = exp;
    e.cyc = cyc + 34;
    sb.push_back(e);
    func3 = f;
    rs1   = a;
    rs2   = b;
    go    = 1'b1;
    @(negedge clk);
    go    = 1'b0;
    func3 = 2'($urandom);
    rs1   = $urandom;
    rs2   = $urandom;
    if (poke_go) begin
      repeat (5) @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
    end
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n = n + 1;
    end
    if (hold_chk) begin
      @(negedge clk);
      chk("rd_hold", rd, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    clr = 1'b1; go = 1'b0; func3 = 2'b00; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_rd", rd, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    clr = 1'b0;
    @(negedge clk);

    // Unsigned
    do_op(2'b01, 32'd100,     32'd10, 32'd10,     1'b0, 1'b1);
    do_op(2'b01, 32'd1000000, 32'd10, 32'd100000, 1'b0, 1'b1);
    do_op(2'b11, 32'd5000,    32'd3,  32'd2,      1'b0, 1'b1);
    do_op(2'b11, 32'd33,      32'd8,  32'd1,      1'b0, 1'b1);
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
    // Signed quotient
    do_op(2'b00, 32'hFFFFFFEB, 32'd3,        32'hFFFFFFF9, 1'b0, 1'b1);
    do_op(2'b00, 32'd33,       32'hFFFFFFFC, 32'hFFFFFFF8, 1'b0, 1'b0);
    do_op(2'b00, 32'hFFFFFFE0, 32'd8,        32'hFFFFFFFC, 1'b0, 1'b0);
    do_op(2'b00, 32'd5000,     32'hFFFFFFFD, 32'hFFFFF97E, 1'b0, 1'b1);
    // Signed remainder
    do_op(2'b10, 32'hFFFFFFDF, 32'd4,        32'hFFFFFFFF, 1'b0, 1'b0);
    do_op(2'b10, 32'd999,      32'hFFFFFFF7, 32'd0,        1'b0, 1'b1);
    do_op(2'b10, 32'hFFFFFFDF, 32'd8,        32'hFFFFFFFF, 1'b0, 1'b0);
    do_op(2'b10, 32'd100,      32'hFFFFFFF6, 32'd0,        1'b0, 1'b0);
    // Divide by zero and signed overflow
    do_op(2'b01, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b1);
    do_op(2'b00, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b1);
    do_op(2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b0, 1'b1);
    do_op(2'b11, 32'd7,        32'd0,        32'd7,        1'b0, 1'b0);
    do_op(2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b1);
    // go re-asserted while running is ignored
    do_op(2'b01, 32'd81, 32'd9, 32'd9, 1'b1, 1'b1);

    // Back-to-back: even i DIVU 6i/3 = 2i, odd i REMU (6i+1)/3 = 1
    r0 = rises;
    for (int i = 0; i < 60; i++) begin
      if (i % 2 == 0) do_op(2'b01, 32'(6 * i),     32'd3, 32'(2 * i), 1'b0, 1'b0);
      else            do_op(2'b11, 32'(6 * i + 1), 32'd3, 32'd1,      1'b0, 1'b0);
    end
    @(negedge clk);
    chk("b2b_rises", 32'(rises - r0), 32'd60);

    // clr mid-operation aborts with no done and clears rd
    func3 = 2'b01; rs1 = 32'd100; rs2 = 32'd10; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_rd", rd, 32'd0);
    chk("clr_done", {31'b0, done}, 32'd0);
    clr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("clr_no_done", {31'b0, done}, 32'd0);
    end
    chk("clr_rd_after", rd, 32'd0);
    do_op(2'b01, 32'd32, 32'd2, 32'd16, 1'b0, 1'b1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
